// File: rtl/fifo_pixel_unpacker.sv
// Pops bytes from a receive FIFO, syncs on a two-byte SOF marker and writes RGB565 pixels to a frame buffer.
// Optional FRAME_TIMEOUT_EN: aborts a frame with a frame_err pulse after TIMEOUT_CYCLES idle cycles.
//   state  | meaning
//   HUNT0  | waiting for SOF0
//   HUNT1  | SOF0 seen, waiting for SOF1
//   PIX_HI | waiting for first byte of a pixel
//   PIX_LO | waiting for second byte of a pixel
module fifo_pixel_unpacker #(
    parameter int         WIDTH          = 160,
    parameter int         HEIGHT         = 120,
    parameter int         ADDR_W         = 15,
    parameter logic [7:0] SOF0           = 8'hFF,
    parameter logic [7:0] SOF1           = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [7:0]        fifo_data,
    output logic              fifo_rd,
    output logic [15:0]       px_data,
    output logic [ADDR_W-1:0] px_addr,
    output logic              px_we,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam bit CFG_OK = ((2.0 ** ADDR_W) >= (WIDTH * HEIGHT)) && (TIMEOUT_CYCLES >= 2);

    if (!CFG_OK) begin : g_cfg_bad
        $error("fifo_pixel_unpacker: ADDR_W too small for frame or TIMEOUT_CYCLES < 2");
    end

    typedef enum logic [1:0] {HUNT0, HUNT1, PIX_HI, PIX_LO} state_t;

    state_t            state, state_n;
    logic              rd_pend;
    logic [7:0]        hi, hi_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [15:0]       px_data_n;
    logic [ADDR_W-1:0] px_addr_n;
    logic              px_we_n, busy_n, done_n, err_n;

    // Gated by reset so nothing is popped (and lost) while held in reset.
    assign fifo_rd = reset && !fifo_empty && !rd_pend;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo, tmo_n;

    always_comb begin
        tmo_n = tmo;
        if (rd_pend || !frame_busy)
            tmo_n = TMO_LOAD;
        else if (tmo != '0)
            tmo_n = tmo - TW'(1);
    end
`endif

    always_comb begin
        state_n   = state;
        hi_n      = hi;
        x_n       = x;
        y_n       = y;
        addr_n    = addr;
        px_data_n = px_data;
        px_addr_n = px_addr;
        px_we_n   = 1'b0;
        busy_n    = frame_busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        if (rd_pend) begin
            case (state)
                HUNT0: begin
                    if (fifo_data == SOF0)
                        state_n = HUNT1;
                end
                HUNT1: begin
                    if (fifo_data == SOF1) begin
                        state_n = PIX_HI;
                        busy_n  = 1'b1;
                        x_n     = '0;
                        y_n     = '0;
                        addr_n  = '0;
                    end else if (fifo_data != SOF0) begin
                        state_n = HUNT0;
                    end
                end
                PIX_HI: begin
                    hi_n    = fifo_data;
                    state_n = PIX_LO;
                end
                PIX_LO: begin
                    px_data_n = {hi, fifo_data};
                    px_addr_n = addr;
                    px_we_n   = 1'b1;
                    if (x == X_LAST) begin
                        x_n = '0;
                        y_n = y + YW'(1);
                    end else begin
                        x_n = x + XW'(1);
                    end
                    if ((x == X_LAST) && (y == Y_LAST)) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = HUNT0;
                        x_n     = '0;
                        y_n     = '0;
                    end else begin
                        state_n = PIX_HI;
                        addr_n  = addr + ADDR_W'(1);
                    end
                end
                default: state_n = HUNT0;
            endcase
        end
`ifdef FRAME_TIMEOUT_EN
        else if (frame_busy && (tmo == '0)) begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = HUNT0;
            hi_n    = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= HUNT0;
            rd_pend    <= 1'b0;
            hi         <= '0;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            px_data    <= '0;
            px_addr    <= '0;
            px_we      <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            tmo        <= '0;
`endif
        end else begin
            state      <= state_n;
            rd_pend    <= fifo_rd;
            hi         <= hi_n;
            x          <= x_n;
            y          <= y_n;
            addr       <= addr_n;
            px_data    <= px_data_n;
            px_addr    <= px_addr_n;
            px_we      <= px_we_n;
            frame_busy <= busy_n;
            frame_done <= done_n;
            frame_err  <= err_n;
`ifdef FRAME_TIMEOUT_EN
            tmo        <= tmo_n;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Directed bench for fifo_pixel_unpacker on a 4x2 frame; a stream-level model predicts every pixel write.
module tb_fifo_pixel_unpacker;
    localparam int W = 4;
    localparam int H = 2;
    localparam int AW = 3;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fifo_empty;
    logic [7:0]    fifo_data = 8'h00;
    logic          fifo_rd;
    logic [15:0]   px_data;
    logic [AW-1:0] px_addr;
    logic          px_we, frame_busy, frame_done, frame_err;

    fifo_pixel_unpacker #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SOF0(8'hFF), .SOF1(8'h00), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .px_data(px_data), .px_addr(px_addr), .px_we(px_we),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Bench-side FIFO: a byte array filled by the stimulus, drained by fifo_rd
    logic [7:0] stim [0:1023];
    int stim_len = 0;
    int rd_idx = 0;
    assign fifo_empty = (rd_idx >= stim_len);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= stim[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    int checks = 0;
    int passes = 0;
    bit in_frame = 0;
    bit prev_ff = 0;
    logic [7:0] fb [0:63];
    int nb = 0;
    int model_idx = 0;
    logic [15:0] exp_d [$];
    int exp_a [$];
    bit exp_done [$];
    logic [15:0] log_d [0:255];
    int log_a [0:255];
    int log_n = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Frame starts after the byte pair FF,00; then every two bytes form one pixel.
    task automatic model_byte(input logic [7:0] b);
        int i;
        if (!in_frame) begin
            if (prev_ff && b == 8'h00) begin
                in_frame = 1;
                nb = 0;
                prev_ff = 0;
            end else begin
                prev_ff = (b == 8'hFF);
            end
        end else begin
            fb[nb] = b;
            nb++;
            if (nb % 2 == 0) begin
                i = nb / 2 - 1;
                exp_d.push_back({fb[2*i], fb[2*i+1]});
                exp_a.push_back(i);
                exp_done.push_back(i == NPIX - 1);
                if (i == NPIX - 1) begin
                    in_frame = 0;
                    prev_ff = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        in_frame = 0;
        prev_ff = 0;
        nb = 0;
        exp_d.delete();
        exp_a.delete();
        exp_done.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        chk("rd_while_empty", {31'd0, fifo_rd && fifo_empty}, 0);
        if (px_we) begin
            chk("write_expected", {31'd0, exp_d.size() != 0}, 1);
            if (exp_d.size() != 0) begin
                chk("px_data", {16'd0, px_data}, {16'd0, exp_d[0]});
                chk("px_addr", {29'd0, px_addr}, exp_a[0]);
                chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done[0]});
                void'(exp_d.pop_front());
                void'(exp_a.pop_front());
                void'(exp_done.pop_front());
            end
            if (log_n < 256) begin
                log_d[log_n] = px_data;
                log_a[log_n] = int'(px_addr);
                log_n++;
            end
        end else begin
            chk("done_without_we", {31'd0, frame_done}, 0);
        end
        if (frame_done) done_cnt++;
`ifdef FRAME_TIMEOUT_EN
        if (frame_err) begin
            err_cnt++;
            chk("we_on_err", {31'd0, px_we}, 0);
            chk("done_on_err", {31'd0, frame_done}, 0);
            model_reset();
        end
`else
        chk("err_low", {31'd0, frame_err}, 0);
`endif
        while (model_idx < rd_idx) begin
            model_byte(stim[model_idx]);
            model_idx++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        stim[stim_len] = b;
        stim_len++;
    endtask

    task automatic send_pixels(input logic [7:0] base);
        for (int i = 0; i < 2 * NPIX; i++) send(base + 8'(i));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rd_idx < stim_len || exp_d.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", {31'd0, n < budget}, 1);
        repeat (4) tick();
    endtask

    int f0, d0;

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rst_px_data", {16'd0, px_data}, 0);
        chk("rst_px_addr", {29'd0, px_addr}, 0);
        chk("rst_we_busy_done_err", {28'd0, px_we, frame_busy, frame_done, frame_err}, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_outputs", {27'd0, fifo_rd, px_we, frame_busy, frame_done, frame_err}, 0);
        end

        // Basic frame: FF 00 01..10
        f0 = log_n; d0 = done_cnt;
        send(8'hFF); send(8'h00); send_pixels(8'h01);
        drain(200);
        chk("f1_px0_data", {16'd0, log_d[f0]}, 32'h0102);
        chk("f1_px0_addr", log_a[f0], 0);
        chk("f1_px7_data", {16'd0, log_d[f0+7]}, 32'h0F10);
        chk("f1_px7_addr", log_a[f0+7], 7);
        chk("f1_writes", log_n - f0, NPIX);
        chk("f1_done_cnt", done_cnt - d0, 1);
        chk("f1_busy_after", {31'd0, frame_busy}, 0);

        // Preamble 12 FF FF 00 then a frame
        f0 = log_n; d0 = done_cnt;
        send(8'h12); send(8'hFF); send(8'hFF); send(8'h00); send_pixels(8'hA0);
        drain(200);
        chk("pre_px0_data", {16'd0, log_d[f0]}, 32'hA0A1);
        chk("pre_px0_addr", log_a[f0], 0);
        chk("pre_writes", log_n - f0, NPIX);
        chk("pre_done_cnt", done_cnt - d0, 1);

        // Marker bytes inside pixel data
        f0 = log_n; d0 = done_cnt;
        send(8'hFF); send(8'h00);
        send(8'h01); send(8'h02); send(8'hFF); send(8'h00);
        for (int i = 5; i <= 16; i++) send(8'(i));
        drain(200);
        chk("mk_px1_data", {16'd0, log_d[f0+1]}, 32'hFF00);
        chk("mk_px1_addr", log_a[f0+1], 1);
        chk("mk_px7_data", {16'd0, log_d[f0+7]}, 32'h0F10);
        chk("mk_writes", log_n - f0, NPIX);
        chk("mk_done_cnt", done_cnt - d0, 1);

        // Reset after 3 pixels, then a full frame
        f0 = log_n; d0 = done_cnt;
        send(8'hFF); send(8'h00);
        for (int i = 0; i < 6; i++) send(8'h20 + 8'(i));
        drain(200);
        chk("rs_partial_writes", log_n - f0, 3);
        chk("rs_busy_mid", {31'd0, frame_busy}, 1);
        reset = 1'b0;
        tick(); tick();
        model_reset();
        reset = 1'b1;
        tick();
        chk("rs_busy_cleared", {31'd0, frame_busy}, 0);
        chk("rs_no_done", done_cnt - d0, 0);
        chk("rs_no_err", err_cnt, 0);
        f0 = log_n;
        send(8'hFF); send(8'h00); send_pixels(8'h30);
        drain(200);
        chk("rs_px0_data", {16'd0, log_d[f0]}, 32'h3031);
        chk("rs_px0_addr", log_a[f0], 0);
        chk("rs_writes", log_n - f0, NPIX);
        chk("rs_done_cnt", done_cnt - d0, 1);

`ifdef FRAME_TIMEOUT_EN
        begin
            int n = 0;
            f0 = log_n; d0 = done_cnt;
            send(8'hFF); send(8'h00); send(8'h40); send(8'h41); send(8'h42);
            while (err_cnt == 0 && n < 200) begin
                tick();
                n++;
            end
            chk("to_err_seen", {31'd0, n < 200}, 1);
            repeat (10) tick();
            chk("to_err_cnt", err_cnt, 1);
            chk("to_writes", log_n - f0, 1);
            chk("to_px0_data", {16'd0, log_d[f0]}, 32'h4041);
            chk("to_busy_after", {31'd0, frame_busy}, 0);
            chk("to_no_done", done_cnt - d0, 0);
            f0 = log_n;
            send(8'hFF); send(8'h00); send_pixels(8'h50);
            drain(200);
            chk("to_next_writes", log_n - f0, NPIX);
            chk("to_next_px0", {16'd0, log_d[f0]}, 32'h5051);
            chk("to_next_done", done_cnt - d0, 1);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fifo_pixel_unpacker.md
Name: fifo_pixel_unpacker

Overview:
Downstream consumer of the UART receive FIFO. It pops bytes from the FIFO read port and hunts for a two-byte start-of-frame marker. After the marker it packs byte pairs into RGB565 pixels and writes them, with a linear address, into a frame buffer write port. It raises a one-cycle done pulse after a complete WIDTH x HEIGHT frame.

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 120, lines per frame
ADDR_W, 15, frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
SOF0, 8'hFF, first start-of-frame marker byte
SOF1, 8'h00, second start-of-frame marker byte
TIMEOUT_CYCLES, 1000000, idle-byte limit inside a frame (used only with FRAME_TIMEOUT_EN)

Ports:
clk  input  1  single system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk)
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO read data; valid the cycle after fifo_rd
fifo_rd  output  1  FIFO pop strobe, one cycle per byte
px_data  output  16  pixel, {first byte, second byte}
px_addr  output  ADDR_W  linear address, y*WIDTH+x
px_we  output  1  one-cycle frame buffer write strobe
frame_busy  output  1  high from SOF detection until the frame ends or aborts
frame_done  output  1  one-cycle pulse on the last pixel write
frame_err  output  1  one-cycle pulse on abort (timeout only)

Behaviour:
- Reset (reset==0 at a clk edge): state=HUNT0, no read pending, all outputs 0, counters 0. Reset applied mid-frame discards the partial frame without a frame_done or frame_err pulse.
- Read handshake: fifo_rd=1 only when fifo_empty==0 and no read is pending. The pending flag is set on that cycle and cleared the next cycle, when fifo_data is captured as a byte. At most one byte is in flight, so throughput is at most one byte per 2 cycles. fifo_rd is never asserted while fifo_empty==1.
- State machine, advanced per captured byte:
  - HUNT0: byte==SOF0 goes to HUNT1; any other byte is dropped.
  - HUNT1: byte==SOF1 goes to PIX_HI and sets frame_busy=1, x=0, y=0, addr=0. Byte==SOF0 stays in HUNT1. Any other byte goes to HUNT0.
  - PIX_HI: latch byte as hi, go to PIX_LO.
  - PIX_LO: px_data={hi,byte}, px_addr=addr, px_we=1 for one cycle, registered on the capture cycle, so it appears 1 cycle after the byte capture.
    - Then x++. If x==WIDTH-1, x=0 and y++.
    - If this pixel is the last one (x==WIDTH-1 and y==HEIGHT-1): frame_done=1 for one cycle together with px_we, frame_busy=0, state goes to HUNT0.
    - Otherwise state goes to PIX_HI and addr++.
- Marker bytes inside a frame are treated as pixel data; they are not re-synchronised.
- px_data and px_addr hold their last values between writes. px_we and frame_done are never high for more than one cycle.
- The block has no backpressure: the frame buffer must accept one write per cycle.
- Wrap-around: addr never exceeds WIDTH*HEIGHT-1. The x and y counters reset to 0 on each new SOF.

Optional Feature:
FRAME_TIMEOUT_EN
- Defined:
  - A counter runs while frame_busy==1.
  - It clears on every byte capture.
  - When it reaches TIMEOUT_CYCLES-1: frame_err=1 for one cycle, frame_busy=0, state goes to HUNT0, pending hi byte discarded, and no px_we on that cycle.
  - frame_done and frame_err are mutually exclusive.
- Undefined: no counter; frame_err is tied to 0; a stalled stream leaves the block waiting in PIX_HI or PIX_LO indefinitely.

Test Plan:
- Reset, then hold fifo_empty=1 for 20 cycles -> fifo_rd, px_we, frame_busy, frame_done and frame_err all stay 0.
- WIDTH=4, HEIGHT=2, stream FF 00 followed by 16 bytes 01..10 -> 8 writes: addr0=0x0102, addr1=0x0304, ..., addr7=0x0F10. frame_done pulses with the addr7 write; frame_busy returns to 0.
- Preamble 12 FF FF 00 followed by a full frame -> the 12 is dropped and FF FF 00 syncs; the first pixel lands at addr0.
- Frame whose pixel bytes include FF 00 -> bytes stored as pixels (e.g. px_data=0xFF00); no resync; exactly WIDTH*HEIGHT writes.
- Assert reset=0 after 3 pixels, release, then send a full frame -> no done or err pulse from the first frame; the new frame starts at addr0 and completes normally.
- FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=50: send SOF plus 3 bytes, then hold empty -> frame_err pulses once after 50 idle cycles, only 1 px_we is seen, and a following full frame completes.
